// File: rtl/pipeline_chain_pkg.sv
// Shared constants and record types for the pipeline register chain.
// The default stage record matches the default top-level WIDTH/REGW.
package pipe_pkg;
    localparam int MAX_STAGES = 8;
    localparam int STG_IDX_W  = 3;
    localparam int FWD_W      = 32;
    localparam int DEF_WIDTH  = 100;
    localparam int DEF_REGW   = 4;

    typedef struct packed {
        logic                valid;
        logic                we;
        logic [DEF_REGW-1:0] wa;
        logic [DEF_WIDTH-1:0] data;
    } stage_rec_t;

    typedef struct packed {
        logic                 hit;
        logic [STG_IDX_W-1:0] stg;
        logic [FWD_W-1:0]     fwd;
    } lkp_t;
endpackage

// File: rtl/pipeline_chain_if.sv
// Producer, control, lookup and retire signals of the pipeline chain.
// master = the surrounding core, slave = the chain itself.
interface pipeline_chain_if #(
    parameter int WIDTH  = 100,
    parameter int STAGES = 3,
    parameter int REGW   = 4
);
    import pipe_pkg::*;

    logic                 in_valid;
    logic [WIDTH-1:0]     in_data;
    logic [REGW-1:0]      in_wa;
    logic                 in_we;
    logic                 in_ready;
    logic [STAGES-1:0]    stall;
    logic [STAGES-1:0]    flush;
    logic [REGW-1:0]      ra1;
    logic [REGW-1:0]      ra2;
    logic                 hit1;
    logic                 hit2;
    logic [FWD_W-1:0]     fwd1;
    logic [FWD_W-1:0]     fwd2;
    logic [STG_IDX_W-1:0] hitstg1;
    logic [STG_IDX_W-1:0] hitstg2;
    logic                 out_valid;
    logic                 out_we;
    logic [WIDTH-1:0]     out_data;
    logic [REGW-1:0]      out_wa;
    logic [3:0]           occ;

    modport master (
        output in_valid, in_data, in_wa, in_we, stall, flush, ra1, ra2,
        input  in_ready, hit1, hit2, fwd1, fwd2, hitstg1, hitstg2,
               out_valid, out_we, out_data, out_wa, occ
    );

    modport slave (
        input  in_valid, in_data, in_wa, in_we, stall, flush, ra1, ra2,
        output in_ready, hit1, hit2, fwd1, fwd2, hitstg1, hitstg2,
               out_valid, out_we, out_data, out_wa, occ
    );
endinterface

// File: rtl/pipeline_chain_stage.sv
// One pipeline stage register: reset > flush > hold > bubble > load.
// Flush and bubble only kill valid/we so the payload stays visible for debug.
module pipe_stage
    import pipe_pkg::*;
#(
    parameter type rec_t = pipe_pkg::stage_rec_t
) (
    input  logic clk,
    input  logic reset,
    input  logic flush,
    input  logic hold,
    input  logic bubble,
    input  rec_t d,
    output rec_t q
);
    rec_t r_q;

    // Stage state update in priority order
    always_ff @(posedge clk) begin
        if (reset) begin
            r_q <= '0;
        end else if (flush) begin
            r_q.valid <= 1'b0;
            r_q.we    <= 1'b0;
        end else if (hold) begin
            r_q <= r_q;
        end else if (bubble) begin
            r_q.valid <= 1'b0;
            r_q.we    <= 1'b0;
        end else begin
            r_q <= d;
        end
    end

    assign q = r_q;
endmodule

// File: rtl/pipeline_chain.sv
// Parametrised E/M/W pipeline register chain with stall/bubble, flush,
// producer back-pressure and a two-port youngest-match forwarding lookup.
module pipeline_chain
    import pipe_pkg::*;
#(
    parameter int WIDTH   = 100,
    parameter int STAGES  = 3,
    parameter int REGW    = 4,
    parameter int FWD_LSB = 0
) (
    input  logic             clk,
    input  logic             reset,
    pipeline_chain_if.slave  bus
);
    typedef struct packed {
        logic             valid;
        logic             we;
        logic [REGW-1:0]  wa;
        logic [WIDTH-1:0] data;
    } rec_t;

    if (STAGES < 2 || STAGES > MAX_STAGES) begin : g_bad_stages
        $error("pipeline_chain: STAGES must be 2..8");
    end

    rec_t                          w_d [STAGES];
    rec_t                          r_q [STAGES];
    logic [STAGES-1:0]             w_hold;
    logic [STAGES-1:0]             w_bubble;
    logic [STAGES-1:0]             w_m1;
    logic [STAGES-1:0]             w_m2;
    logic [STAGES-1:0][FWD_W-1:0]  w_res;
    logic [3:0]                    w_occ;
    lkp_t                          w_l1;
    lkp_t                          w_l2;

    // Youngest matching stage wins, so scan oldest to youngest
    function automatic lkp_t pick(input logic [STAGES-1:0] m,
                                  input logic [STAGES-1:0][FWD_W-1:0] res);
        lkp_t r;
        r = '0;
        for (int k = STAGES - 1; k >= 0; k--) begin
            if (m[k]) begin
                r.hit = 1'b1;
                r.stg = STG_IDX_W'(k);
                r.fwd = res[k];
            end else begin
                r = r;
            end
        end
        return r;
    endfunction

    // A stall on stage k freezes k and every younger stage
    always_comb begin
        w_hold = '0;
        for (int k = 0; k < STAGES; k++) begin
            w_hold[k] = |(bus.stall >> k);
        end
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        if (k == 0) begin : g_head
            assign w_d[k]      = '{valid: bus.in_valid, we: bus.in_we & bus.in_valid,
                                   wa: bus.in_wa, data: bus.in_data};
            assign w_bubble[k] = 1'b0;
        end else begin : g_body
            assign w_d[k]      = r_q[k-1];
            assign w_bubble[k] = w_hold[k-1];
        end

        pipe_stage #(.rec_t(rec_t)) u_stage (
            .clk    (clk),
            .reset  (reset),
            .flush  (bus.flush[k]),
            .hold   (w_hold[k]),
            .bubble (w_bubble[k]),
            .d      (w_d[k]),
            .q      (r_q[k])
        );
    end

    // Per-stage match vectors, result fields and occupancy
    always_comb begin
        w_m1  = '0;
        w_m2  = '0;
        w_res = '0;
        w_occ = 4'd0;
        for (int k = 0; k < STAGES; k++) begin
            w_res[k] = r_q[k].data[FWD_LSB +: FWD_W];
            w_m1[k]  = r_q[k].valid & r_q[k].we & (r_q[k].wa == bus.ra1);
            w_m2[k]  = r_q[k].valid & r_q[k].we & (r_q[k].wa == bus.ra2);
            w_occ    = w_occ + {3'b000, r_q[k].valid};
        end
    end

    assign w_l1 = pick(w_m1, w_res);
    assign w_l2 = pick(w_m2, w_res);

    assign bus.in_ready  = ~w_hold[0];
    assign bus.hit1      = w_l1.hit;
    assign bus.hitstg1   = w_l1.stg;
    assign bus.fwd1      = w_l1.fwd;
    assign bus.hit2      = w_l2.hit;
    assign bus.hitstg2   = w_l2.stg;
    assign bus.fwd2      = w_l2.fwd;
    assign bus.out_valid = r_q[STAGES-1].valid;
    assign bus.out_we    = r_q[STAGES-1].we;
    assign bus.out_wa    = r_q[STAGES-1].wa;
    assign bus.out_data  = r_q[STAGES-1].data;
    assign bus.occ       = w_occ;
endmodule

// File: tb/tb_pipeline_chain.sv
// Directed bench for pipeline_chain with STAGES=3, WIDTH=100, REGW=4.
module tb_pipeline_chain;
    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    pipeline_chain_if #(.WIDTH(100), .STAGES(3), .REGW(4)) bus ();

    pipeline_chain #(.WIDTH(100), .STAGES(3), .REGW(4), .FWD_LSB(0)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.in_valid = 1'b0; bus.in_data = '0; bus.in_wa = '0; bus.in_we = 1'b0;
        bus.stall = 3'b000; bus.flush = 3'b000; bus.ra1 = 4'd0; bus.ra2 = 4'd0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b1;
        tick(); tick();
        reset = 1'b0;
    endtask

    task automatic feed(input logic [99:0] d, input logic [3:0] wa, input logic we);
        bus.in_valid = 1'b1; bus.in_data = d; bus.in_wa = wa; bus.in_we = we;
        tick();
        bus.in_valid = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %0b exp 0", bus.out_valid); end
        checks++; if (bus.occ !== 4'd0) begin errors++; $display("FAIL reset_occ got %0d exp 0", bus.occ); end
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %0b exp 1", bus.in_ready); end
        checks++; if (bus.hit1 !== 1'b0 || bus.fwd1 !== 32'd0 || bus.hitstg1 !== 3'd0) begin errors++; $display("FAIL reset_lookup hit %0b fwd %0h stg %0d exp 0/0/0", bus.hit1, bus.fwd1, bus.hitstg1); end
        checks++; if (bus.out_data !== 100'd0 || bus.out_wa !== 4'd0 || bus.out_we !== 1'b0) begin errors++; $display("FAIL reset_out_fields data %0h wa %0d we %0b exp 0", bus.out_data, bus.out_wa, bus.out_we); end
    endtask

    task automatic test_stream();
        logic [99:0] exp_d;
        int exp_occ;
        do_reset();
        for (int i = 0; i < 5; i++) begin
            feed(100'(i), 4'(i + 1), 1'b1);
            exp_occ = (i + 1 < 3) ? i + 1 : 3;
            checks++; if (bus.out_valid !== (i >= 2)) begin errors++; $display("FAIL stream_valid[%0d] got %0b exp %0b", i, bus.out_valid, (i >= 2)); end
            checks++; if (bus.occ !== 4'(exp_occ)) begin errors++; $display("FAIL stream_occ[%0d] got %0d exp %0d", i, bus.occ, exp_occ); end
            if (i >= 2) begin
                exp_d = 100'(i - 2);
                checks++; if (bus.out_data !== exp_d || bus.out_wa !== 4'(i - 1) || bus.out_we !== 1'b1) begin errors++; $display("FAIL stream_out[%0d] data %0d wa %0d we %0b exp %0d/%0d/1", i, bus.out_data, bus.out_wa, bus.out_we, exp_d, i - 1); end
            end
        end
        for (int j = 0; j < 3; j++) begin
            tick();
            checks++; if (bus.occ !== 4'(2 - j)) begin errors++; $display("FAIL drain_occ[%0d] got %0d exp %0d", j, bus.occ, 2 - j); end
            checks++; if (bus.out_valid !== (j < 2)) begin errors++; $display("FAIL drain_valid[%0d] got %0b exp %0b", j, bus.out_valid, (j < 2)); end
            if (j < 2) begin
                exp_d = 100'(j + 3);
                checks++; if (bus.out_data !== exp_d) begin errors++; $display("FAIL drain_data[%0d] got %0d exp %0d", j, bus.out_data, exp_d); end
            end
        end
    endtask

    task automatic test_stall_mid();
        logic [99:0] exp_d;
        do_reset();
        feed(100'd10, 4'd1, 1'b1); feed(100'd11, 4'd1, 1'b1); feed(100'd12, 4'd1, 1'b1);
        checks++; if (bus.out_valid !== 1'b1 || bus.out_data !== 100'd10) begin errors++; $display("FAIL stall1_pre got v%0b d%0d exp v1 d10", bus.out_valid, bus.out_data); end
        bus.in_valid = 1'b1; bus.in_data = 100'd13; bus.stall = 3'b010;
        for (int c = 0; c < 2; c++) begin
            #1;
            checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL stall1_ready[%0d] got %0b exp 0", c, bus.in_ready); end
            tick();
            checks++; if (bus.out_valid !== 1'b0 || bus.occ !== 4'd2) begin errors++; $display("FAIL stall1_bubble[%0d] v%0b occ %0d exp v0 occ 2", c, bus.out_valid, bus.occ); end
        end
        bus.stall = 3'b000;
        #1;
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL stall1_release got %0b exp 1", bus.in_ready); end
        tick();
        bus.in_valid = 1'b0;
        for (int j = 0; j < 3; j++) begin
            exp_d = 100'(11 + j);
            checks++; if (bus.out_valid !== 1'b1 || bus.out_data !== exp_d) begin errors++; $display("FAIL stall1_order[%0d] v%0b d%0d exp v1 d%0d", j, bus.out_valid, bus.out_data, exp_d); end
            tick();
        end
        checks++; if (bus.out_valid !== 1'b0 || bus.occ !== 4'd0) begin errors++; $display("FAIL stall1_empty v%0b occ %0d exp v0 occ 0", bus.out_valid, bus.occ); end
    endtask

    task automatic test_stall_head();
        do_reset();
        feed(100'd20, 4'd1, 1'b1); feed(100'd21, 4'd1, 1'b1); feed(100'd22, 4'd1, 1'b1);
        bus.in_valid = 1'b1; bus.in_data = 100'd23; bus.stall = 3'b001;
        #1;
        checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL stall0_ready got %0b exp 0", bus.in_ready); end
        tick();
        checks++; if (bus.out_valid !== 1'b1 || bus.out_data !== 100'd21 || bus.occ !== 4'd2) begin errors++; $display("FAIL stall0_hold v%0b d%0d occ %0d exp v1 d21 occ 2", bus.out_valid, bus.out_data, bus.occ); end
        bus.stall = 3'b000;
        tick();
        bus.in_valid = 1'b0;
        checks++; if (bus.out_valid !== 1'b0 || bus.occ !== 4'd2) begin errors++; $display("FAIL stall0_bubble v%0b occ %0d exp v0 occ 2", bus.out_valid, bus.occ); end
        tick();
        checks++; if (bus.out_valid !== 1'b1 || bus.out_data !== 100'd22) begin errors++; $display("FAIL stall0_next v%0b d%0d exp v1 d22", bus.out_valid, bus.out_data); end
        tick();
        checks++; if (bus.out_valid !== 1'b1 || bus.out_data !== 100'd23) begin errors++; $display("FAIL stall0_last v%0b d%0d exp v1 d23", bus.out_valid, bus.out_data); end
    endtask

    task automatic test_flush();
        do_reset();
        feed(100'd30, 4'd1, 1'b1); feed(100'd31, 4'd1, 1'b1); feed(100'd32, 4'd1, 1'b1);
        bus.flush = 3'b011;
        tick();
        bus.flush = 3'b000;
        checks++; if (bus.occ !== 4'd1 || bus.out_valid !== 1'b1 || bus.out_data !== 100'd31) begin errors++; $display("FAIL flush011 occ %0d v%0b d%0d exp occ 1 v1 d31", bus.occ, bus.out_valid, bus.out_data); end
        tick();
        checks++; if (bus.occ !== 4'd0) begin errors++; $display("FAIL flush011_after occ got %0d exp 0", bus.occ); end
        do_reset();
        feed(100'd40, 4'd1, 1'b1); feed(100'd41, 4'd1, 1'b1); feed(100'd42, 4'd1, 1'b1);
        bus.flush = 3'b001; bus.stall = 3'b001;
        tick();
        bus.flush = 3'b000; bus.stall = 3'b000;
        checks++; if (bus.occ !== 4'd1 || bus.out_data !== 100'd41) begin errors++; $display("FAIL flush_over_stall occ %0d d%0d exp occ 1 d41", bus.occ, bus.out_data); end
    endtask

    task automatic test_forward();
        do_reset();
        feed(100'h50, 4'd5, 1'b1); feed(100'h60, 4'd7, 1'b1); feed(100'h70, 4'd5, 1'b1);
        bus.stall = 3'b111; bus.ra1 = 4'd5; bus.ra2 = 4'd7;
        #1;
        checks++; if (bus.hit1 !== 1'b1 || bus.hitstg1 !== 3'd0 || bus.fwd1 !== 32'h70) begin errors++; $display("FAIL fwd_youngest hit %0b stg %0d fwd %0h exp 1/0/70", bus.hit1, bus.hitstg1, bus.fwd1); end
        checks++; if (bus.hit2 !== 1'b1 || bus.hitstg2 !== 3'd1 || bus.fwd2 !== 32'h60) begin errors++; $display("FAIL fwd_port2 hit %0b stg %0d fwd %0h exp 1/1/60", bus.hit2, bus.hitstg2, bus.fwd2); end
        bus.ra2 = 4'd9;
        #1;
        checks++; if (bus.hit2 !== 1'b0 || bus.hitstg2 !== 3'd0 || bus.fwd2 !== 32'd0) begin errors++; $display("FAIL fwd_miss hit %0b stg %0d fwd %0h exp 0/0/0", bus.hit2, bus.hitstg2, bus.fwd2); end
        bus.flush = 3'b001;
        tick();
        bus.flush = 3'b000;
        checks++; if (bus.hit1 !== 1'b1 || bus.hitstg1 !== 3'd2 || bus.fwd1 !== 32'h50) begin errors++; $display("FAIL fwd_invalid_skip hit %0b stg %0d fwd %0h exp 1/2/50", bus.hit1, bus.hitstg1, bus.fwd1); end
        do_reset();
        feed(100'h80, 4'd5, 1'b0); feed(100'h90, 4'd15, 1'b1); feed(100'hA0, 4'd3, 1'b1);
        bus.ra1 = 4'd5; bus.ra2 = 4'd15;
        #1;
        checks++; if (bus.hit1 !== 1'b0 || bus.fwd1 !== 32'd0 || bus.hitstg1 !== 3'd0) begin errors++; $display("FAIL fwd_we0 hit %0b stg %0d fwd %0h exp 0/0/0", bus.hit1, bus.hitstg1, bus.fwd1); end
        checks++; if (bus.hit2 !== 1'b1 || bus.hitstg2 !== 3'd1 || bus.fwd2 !== 32'h90) begin errors++; $display("FAIL fwd_reg15 hit %0b stg %0d fwd %0h exp 1/1/90", bus.hit2, bus.hitstg2, bus.fwd2); end
        bus.ra1 = 4'd3;
        #1;
        checks++; if (bus.hit1 !== 1'b1 || bus.hitstg1 !== 3'd0 || bus.fwd1 !== 32'hA0) begin errors++; $display("FAIL fwd_stage0 hit %0b stg %0d fwd %0h exp 1/0/A0", bus.hit1, bus.hitstg1, bus.fwd1); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        feed(100'h11, 4'd2, 1'b1); feed(100'h22, 4'd2, 1'b1); feed(100'h33, 4'd2, 1'b1);
        bus.stall = 3'b111; bus.ra1 = 4'd2; bus.ra2 = 4'd2;
        #1;
        checks++; if (bus.occ !== 4'd3 || bus.hit1 !== 1'b1) begin errors++; $display("FAIL rstmid_pre occ %0d hit %0b exp 3/1", bus.occ, bus.hit1); end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++; if (bus.occ !== 4'd0 || bus.out_valid !== 1'b0) begin errors++; $display("FAIL rstmid_state occ %0d v%0b exp 0/0", bus.occ, bus.out_valid); end
        checks++; if (bus.hit1 !== 1'b0 || bus.hit2 !== 1'b0) begin errors++; $display("FAIL rstmid_hit hit1 %0b hit2 %0b exp 0/0", bus.hit1, bus.hit2); end
        bus.stall = 3'b000;
        #1;
        checks++; if (bus.in_ready !== 1'b1 || bus.out_data !== 100'd0) begin errors++; $display("FAIL rstmid_ready rdy %0b d%0h exp 1/0", bus.in_ready, bus.out_data); end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_stall_mid();
        test_stall_head();
        test_flush();
        test_forward();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
